// File: rtl/reaction_timer.sv
// Reaction-time measurement stage: random delay, lamp on, then count whole
// milliseconds until react; publishes a binary score plus three BCD digits.
module reaction_timer #(
    parameter int TICK_DIV       = 50000,
    parameter int WAIT_MIN_MS    = 1000,
    parameter int WAIT_RAND_BITS = 11,
    parameter int MAX_MS         = 999
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        react,
    output logic        led,
    output logic        busy,
    output logic        done,
    output logic        false_start,
    output logic        timeout,
    output logic [11:0] score,
    output logic [3:0]  dig0,
    output logic [3:0]  dig1,
    output logic [3:0]  dig2
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WAIT_W = $clog2(WAIT_MIN_MS + (1 << WAIT_RAND_BITS) + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ARMED = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]        btn_meta_reg, btn_sync_reg, btn_prev_reg, btn_edge_reg;
    logic              start_edge, react_edge;
    logic [15:0]       lfsr_reg;
    logic [PRE_W-1:0]  pre_reg;
    logic              tick;
    logic [WAIT_W-1:0] wait_reg;
    logic [9:0]        ms_reg;
    logic [3:0]        bcd0_reg, bcd1_reg, bcd2_reg;
    logic              done_reg, false_start_reg, timeout_reg;
    logic [11:0]       score_reg;
    logic [3:0]        dig0_reg, dig1_reg, dig2_reg;
    logic              load_wait, arm_entry, pub_false, pub_valid, pub_timeout;

    // Bit 0 is start, bit 1 is react; the edge pulse is registered so it lands
    // on the third clock edge after the button rises.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_meta_reg <= 2'b00;
            btn_sync_reg <= 2'b00;
            btn_prev_reg <= 2'b00;
            btn_edge_reg <= 2'b00;
        end else begin
            btn_meta_reg <= {react, start};
            btn_sync_reg <= btn_meta_reg;
            btn_prev_reg <= btn_sync_reg;
            btn_edge_reg <= btn_sync_reg & ~btn_prev_reg;
        end
    end

    assign start_edge = btn_edge_reg[0];
    assign react_edge = btn_edge_reg[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
        end
    end

    assign tick = (pre_reg == PRE_W'(TICK_DIV - 1));

    // Restarting the prescaler on phase entry makes the first tick land exactly
    // one full millisecond after the phase begins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_reg <= '0;
        end else if (load_wait || arm_entry || tick) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_reg + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_edge) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (react_edge)                                state_next = S_IDLE;
                else if (tick && (wait_reg <= WAIT_W'(1)))     state_next = S_ARMED;
            end
            S_ARMED: begin
                if (react_edge)                                state_next = S_IDLE;
                else if (tick && (ms_reg == 10'(MAX_MS)))      state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // React is checked first in both busy states so it wins against a
    // coincident final-wait tick or timeout tick.
    always_comb begin
        led         = 1'b0;
        busy        = 1'b0;
        load_wait   = 1'b0;
        arm_entry   = 1'b0;
        pub_false   = 1'b0;
        pub_valid   = 1'b0;
        pub_timeout = 1'b0;
        case (state_reg)
            S_IDLE: begin
                load_wait = start_edge;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (react_edge)                                pub_false = 1'b1;
                else if (tick && (wait_reg <= WAIT_W'(1)))     arm_entry = 1'b1;
            end
            S_ARMED: begin
                led  = 1'b1;
                busy = 1'b1;
                if (react_edge)                                pub_valid   = 1'b1;
                else if (tick && (ms_reg == 10'(MAX_MS)))      pub_timeout = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_reg <= '0;
        end else if (load_wait) begin
            wait_reg <= WAIT_W'(WAIT_MIN_MS) + WAIT_W'(lfsr_reg[WAIT_RAND_BITS-1:0]);
        end else if ((state_reg == S_WAIT) && tick && (wait_reg != '0)) begin
            wait_reg <= wait_reg - WAIT_W'(1);
        end
    end

    // Binary and BCD counts advance together so publishing needs no conversion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_reg   <= '0;
            bcd0_reg <= '0;
            bcd1_reg <= '0;
            bcd2_reg <= '0;
        end else if (arm_entry) begin
            ms_reg   <= '0;
            bcd0_reg <= '0;
            bcd1_reg <= '0;
            bcd2_reg <= '0;
        end else if ((state_reg == S_ARMED) && tick) begin
            ms_reg <= ms_reg + 10'd1;
            if (bcd0_reg == 4'd9) begin
                bcd0_reg <= 4'd0;
                if (bcd1_reg == 4'd9) begin
                    bcd1_reg <= 4'd0;
                    bcd2_reg <= (bcd2_reg == 4'd9) ? 4'd0 : bcd2_reg + 4'd1;
                end else begin
                    bcd1_reg <= bcd1_reg + 4'd1;
                end
            end else begin
                bcd0_reg <= bcd0_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done_reg        <= 1'b0;
            false_start_reg <= 1'b0;
            timeout_reg     <= 1'b0;
            score_reg       <= 12'hFFF;
            dig0_reg        <= 4'd0;
            dig1_reg        <= 4'd0;
            dig2_reg        <= 4'd0;
        end else begin
            done_reg <= pub_false | pub_valid | pub_timeout;
            if (load_wait) begin
                false_start_reg <= 1'b0;
                timeout_reg     <= 1'b0;
            end else if (pub_false) begin
                false_start_reg <= 1'b1;
                score_reg       <= 12'hFFF;
                dig0_reg        <= 4'hF;
                dig1_reg        <= 4'hF;
                dig2_reg        <= 4'hF;
            end else if (pub_valid) begin
                score_reg <= {2'b00, ms_reg};
                dig0_reg  <= bcd0_reg;
                dig1_reg  <= bcd1_reg;
                dig2_reg  <= bcd2_reg;
            end else if (pub_timeout) begin
                timeout_reg <= 1'b1;
                score_reg   <= 12'hFFF;
                dig0_reg    <= 4'd9;
                dig1_reg    <= 4'd9;
                dig2_reg    <= 4'd9;
            end
        end
    end

    assign done        = done_reg;
    assign false_start = false_start_reg;
    assign timeout     = timeout_reg;
    assign score       = score_reg;
    assign dig0        = dig0_reg;
    assign dig1        = dig1_reg;
    assign dig2        = dig2_reg;

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: directed trial sequence with randomized reaction
// times, checked against a cycle-count model of the trial timing.
module tb_reaction_timer;

    localparam int TD    = 10;
    localparam int WMIN  = 5;
    localparam int WBITS = 3;
    localparam int MAXMS = 999;

    logic        clk    = 1'b0;
    logic        resetn = 1'b1;
    logic        start  = 1'b0;
    logic        react  = 1'b0;
    logic        led, busy, done, false_start, timeout;
    logic [11:0] score;
    logic [3:0]  dig0, dig1, dig2;

    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int done_cnt = 0;

    // Expected published values
    int m_score = 12'hFFF;
    int m_d0 = 0, m_d1 = 0, m_d2 = 0;
    int m_fs = 0, m_to = 0;

    reaction_timer #(
        .TICK_DIV(TD), .WAIT_MIN_MS(WMIN), .WAIT_RAND_BITS(WBITS), .MAX_MS(MAXMS)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .react(react),
        .led(led), .busy(busy), .done(done), .false_start(false_start),
        .timeout(timeout), .score(score), .dig0(dig0), .dig1(dig1), .dig2(dig2)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no end of run, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // LFSR contents after k clock edges from the seed; taps counted 1..16 from the output end.
    function automatic logic [15:0] lfsr_after(input int k);
        logic [15:0] l;
        logic        fb;
        int          taps [4];
        taps = '{16, 14, 13, 11};
        l = 16'hACE1;
        for (int i = 0; i < k; i++) begin
            fb = 1'b0;
            foreach (taps[j]) fb = fb ^ l[16 - taps[j]];
            l = {fb, l[15:1]};
        end
        return l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pub(input string tag);
        chk({tag, "_score"}, 32'(score), 32'(m_score));
        chk({tag, "_dig0"}, 32'(dig0), 32'(m_d0));
        chk({tag, "_dig1"}, 32'(dig1), 32'(m_d1));
        chk({tag, "_dig2"}, 32'(dig2), 32'(m_d2));
        chk({tag, "_fs"}, 32'(false_start), 32'(m_fs));
        chk({tag, "_to"}, 32'(timeout), 32'(m_to));
    endtask

    task automatic go_to(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 30000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < target) begin
            fails++;
            $error("FAIL go_to: observed cycle %0d required %0d", cyc, target);
        end
    endtask

    // Press start now; returns press cycle n and expected lamp-on cycle l.
    task automatic start_trial(input string tag, output int n, output int l);
        logic [15:0] lf;
        int          w;
        n     = cyc;
        start = 1'b1;
        lf    = lfsr_after(n + 3);
        w     = WMIN + int'(lf[WBITS-1:0]);
        l     = n + 4 + TD * w;
        go_to(n + 3);
        chk({tag, "_busy_pre"}, 32'(busy), 32'd0);
        go_to(n + 4);
        m_fs = 0;
        m_to = 0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_done_start"}, 32'(done), 32'd0);
        check_pub({tag, "_start"});
        start = 1'b0;
    endtask

    task automatic check_arm(input string tag, input int l);
        go_to(l - 1);
        chk({tag, "_led_pre"}, 32'(led), 32'd0);
        go_to(l);
        chk({tag, "_led_on"}, 32'(led), 32'd1);
        chk({tag, "_busy_arm"}, 32'(busy), 32'd1);
    endtask

    // Press react at cycle m while armed; it is taken at edge m+4.
    task automatic finish_valid(input string tag, input int l, input int m);
        int d0, s;
        go_to(m);
        react = 1'b1;
        d0    = done_cnt;
        go_to(m + 3);
        chk({tag, "_done_pre"}, 32'(done), 32'd0);
        chk({tag, "_score_hold"}, 32'(score), 32'(m_score));
        go_to(m + 4);
        s       = (m + 4 - l - 1) / TD;
        m_score = s;
        m_d0    = s % 10;
        m_d1    = (s / 10) % 10;
        m_d2    = s / 100;
        chk({tag, "_done"}, 32'(done), 32'd1);
        check_pub(tag);
        chk({tag, "_led_off"}, 32'(led), 32'd0);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        react = 1'b0;
        go_to(m + 5);
        chk({tag, "_done_fall"}, 32'(done), 32'd0);
        chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int n, l, m, d0;
        logic led_seen;

        // Reset state
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        check_pub("rst");
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Directed 437 ms trial with start re-pressed during WAIT and ARMED
        start_trial("t437", n, l);
        go_to(n + 12); start = 1'b1;
        go_to(n + 20); start = 1'b0;
        check_arm("t437", l);
        go_to(l + 20); start = 1'b1;
        go_to(l + 30); start = 1'b0;
        go_to(l + 100);
        check_pub("t437_armed_hold");
        finish_valid("t437", l, l + 4375);

        // Randomized reaction times
        for (int t = 0; t < 5; t++) begin
            start_trial("rnd", n, l);
            check_arm("rnd", l);
            m = l + int'($urandom_range(4, 1500)) - 4;
            finish_valid("rnd", l, m);
        end

        // False start somewhere in WAIT
        start_trial("fs", n, l);
        m = int'($urandom_range(n + 6, l - 5));
        go_to(m);
        react = 1'b1;
        go_to(m + 4);
        m_fs = 1; m_score = 12'hFFF; m_d0 = 15; m_d1 = 15; m_d2 = 15;
        chk("fs_done", 32'(done), 32'd1);
        check_pub("fs");
        chk("fs_busy", 32'(busy), 32'd0);
        led_seen = 1'b0;
        while (cyc < l + 20) begin
            @(negedge clk);
            led_seen = led_seen | led;
        end
        chk("fs_led_never", 32'(led_seen), 32'd0);
        react = 1'b0;
        go_to(cyc + 5);

        // React coincident with the final WAIT tick
        start_trial("fsedge", n, l);
        go_to(l - 4);
        react = 1'b1;
        go_to(l - 1);
        chk("fsedge_led_pre", 32'(led), 32'd0);
        go_to(l);
        m_fs = 1;
        chk("fsedge_done", 32'(done), 32'd1);
        chk("fsedge_led", 32'(led), 32'd0);
        check_pub("fsedge");
        react = 1'b0;
        go_to(cyc + 5);

        // Timeout
        start_trial("tmo", n, l);
        check_arm("tmo", l);
        go_to(l + TD * (MAXMS + 1) - 1);
        chk("tmo_done_pre", 32'(done), 32'd0);
        chk("tmo_led_pre", 32'(led), 32'd1);
        go_to(l + TD * (MAXMS + 1));
        m_to = 1; m_score = 12'hFFF; m_d0 = 9; m_d1 = 9; m_d2 = 9;
        chk("tmo_done", 32'(done), 32'd1);
        chk("tmo_led", 32'(led), 32'd0);
        check_pub("tmo");
        go_to(cyc + 5);

        // React on the same cycle as the timeout tick
        start_trial("rtmo", n, l);
        check_arm("rtmo", l);
        finish_valid("rtmo", l, l + TD * (MAXMS + 1) - 4);

        // Start and react rise together; react then held through WAIT
        react = 1'b1;
        start_trial("held", n, l);
        check_arm("held", l);
        chk("held_fs", 32'(false_start), 32'd0);
        go_to(l + 5);
        react = 1'b0;
        finish_valid("held", l, l + 200 + int'($urandom_range(0, 300)));

        // Reset in the middle of ARMED
        start_trial("rmid", n, l);
        check_arm("rmid", l);
        go_to(l + 50);
        d0 = done_cnt;
        resetn = 1'b0;
        #1;
        m_score = 12'hFFF; m_d0 = 0; m_d1 = 0; m_d2 = 0; m_fs = 0; m_to = 0;
        chk("rmid_led", 32'(led), 32'd0);
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_done", 32'(done), 32'd0);
        check_pub("rmid");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        go_to(5);
        chk("rmid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rmid_idle", 32'(busy), 32'd0);

        // Fresh trial after reset
        start_trial("post", n, l);
        check_arm("post", l);
        finish_valid("post", l, l + int'($urandom_range(4, 800)) - 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Measurement stage of the reaction-time game.
- Runs one trial per start press: random delay, then LED on, then counts milliseconds until the player presses react.
- Produces a 12-bit binary score and three BCD digits, which feed the downstream high-score keeper directly.
- Invalid trials report score 12'hFFF, so the high-score stage ignores them.

Parameters:
- TICK_DIV, 50000, clock cycles per 1 ms tick (50 MHz clock).
- WAIT_MIN_MS, 1000, minimum random delay in ms.
- WAIT_RAND_BITS, 11, number of LFSR bits added to the delay (0..2^N-1 ms).
- MAX_MS, 999, highest valid reaction time; the trial times out beyond this.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  start button, asynchronous level, active-high
- react  input  1  reaction button, asynchronous level, active-high
- led  output  1  stimulus lamp; high only in ARMED
- busy  output  1  high in WAIT or ARMED
- done  output  1  one-cycle pulse when a result is published
- false_start  output  1  last trial ended by an early press; held until next start
- timeout  output  1  last trial exceeded MAX_MS; held until next start
- score  output  12  last result in binary ms; 12'hFFF when invalid
- dig0  output  4  BCD ones of last result
- dig1  output  4  BCD tens of last result
- dig2  output  4  BCD hundreds of last result

Behaviour:
- Reset is asynchronous, active-low. While reset is asserted:
  - state=IDLE, led=0, busy=0, done=0, false_start=0, timeout=0.
  - score=12'hFFF, dig0..2=0.
  - LFSR=16'hACE1; tick and ms counters cleared.
- Reset mid-trial aborts the trial with no done pulse.
- Inputs: start and react each pass through a 2-FF synchronizer, then a rising-edge detector.
  - The edge pulse appears on the 3rd rising clk edge after the input rises.
  - Holding a button produces no further pulses.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock, never stalls.
- Tick: prescaler counts 0..TICK_DIV-1 and pulses tick on the wrap.
  - The prescaler clears on entry to WAIT and on entry to ARMED, so the first tick comes exactly TICK_DIV cycles later.
- IDLE:
  - Holds the last result on score/digits.
  - start edge -> WAIT. On this transition:
    - wait_ms = WAIT_MIN_MS + lfsr[WAIT_RAND_BITS-1:0].
    - false_start=0, timeout=0.
    - score and digits are NOT changed.
  - react edge in IDLE is ignored.
- WAIT:
  - wait_ms decrements on each tick. Reaching 0 -> ARMED; led=1 from the first cycle of ARMED.
  - react edge -> IDLE, false_start=1, score=12'hFFF, dig0..2=4'hF, done pulse.
  - If a react edge and the final tick occur in the same cycle, react wins (false start).
- ARMED:
  - ms counter (binary 10-bit plus 3-digit BCD in lockstep) starts at 0 and increments on each tick.
  - BCD digits carry 9->0 into the next digit.
  - react edge -> IDLE, led=0, done pulse. Published values:
    - score = current ms count, zero-extended to 12 bits.
    - dig0..2 = the current BCD digits.
    - These equal the number of fully elapsed ms (floor).
  - Timeout: a tick while count==MAX_MS -> IDLE, timeout=1, score=12'hFFF, dig2..0=9,9,9, done pulse.
  - If a react edge and the timeout tick occur in the same cycle, react wins (score 999).
- start edges in WAIT or ARMED are ignored.
- Publishing:
  - score, dig0..2, false_start and timeout update on the same clk edge that raises done.
  - They stay stable until the next publish, so the downstream stage sees exactly one score change per trial.
- A rising start and react edge in the same IDLE cycle: start taken, react dropped.

Test Plan:
- Sim parameters: TICK_DIV=10, WAIT_MIN_MS=5, WAIT_RAND_BITS=3, MAX_MS=999.
- Reset: assert resetn=0 mid-ARMED -> led=0, busy=0, score=12'hFFF, digits 0, no done pulse.
- Valid trial: start pulse, wait for led rise, press react 437 ticks + 5 cycles after led rise -> done once; score=437, dig2..0=4,3,7; led=0 next cycle.
- False start: press react during WAIT -> false_start=1, score=12'hFFF, digits F,F,F, led never rises.
- Timeout: never press react -> 1000 ticks after led rise: timeout=1, score=12'hFFF, digits 9,9,9, done pulse.
- Boundaries:
  - react on the same cycle as the timeout tick -> score=999, timeout=0.
  - react coincident with the final WAIT tick -> false_start=1.
- Ignored inputs: re-press start during WAIT/ARMED, hold react across a new start -> no restart; held react produces no false start; score unchanged until done.
